// File: rtl/layer_serializer.sv
// Parallel-to-serial stage: captures NN neuron words when all are valid and replays them
// one word per cycle. Optional sticky overrun flag under LAYER_SER_OVERRUN_EN.
module layer_serializer #(
  parameter int unsigned NN        = 10,
  parameter int unsigned dataWidth = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NN-1:0]             i_valid,
  input  logic [NN*dataWidth-1:0]   i_data,
  output logic                      x_valid,
  output logic [dataWidth-1:0]      x_out,
  output logic                      x_last,
  output logic                      busy
`ifdef LAYER_SER_OVERRUN_EN
  , output logic                    overrun
`endif
);

  localparam int unsigned CNT_W = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NN*dataWidth-1:0]   data_q, data_d;
  logic                      x_valid_q, x_valid_d;
  logic [dataWidth-1:0]      x_out_q, x_out_d;
  logic                      x_last_q, x_last_d;
  logic                      busy_q, busy_d;
`ifdef LAYER_SER_OVERRUN_EN
  logic                      overrun_q, overrun_d;
`endif

  logic                      capture_c;
  logic                      at_last_c;
  logic [CNT_W-1:0]          cnt_inc_c;

  assign capture_c = &i_valid;
  assign at_last_c = (cnt_q == LAST_IDX);
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  function automatic logic [dataWidth-1:0] word_at(input logic [NN*dataWidth-1:0] v,
                                                   input logic [CNT_W-1:0]        idx);
    return v[32'(idx)*dataWidth +: dataWidth];
  endfunction

  // Next-state and registered-output decode; the output regs carry the word shown next cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    x_valid_d = 1'b0;
    x_out_d   = '0;
    x_last_d  = 1'b0;
`ifdef LAYER_SER_OVERRUN_EN
    overrun_d = overrun_q;
`endif
    case (state_q)
      IDLE: begin
        if (capture_c) begin
          data_d    = i_data;
          cnt_d     = '0;
          state_d   = SHIFT;
          x_valid_d = 1'b1;
          x_out_d   = word_at(i_data, '0);
        end
      end
      SHIFT: begin
        if (at_last_c) begin
          if (capture_c) begin
            data_d    = i_data;
            cnt_d     = '0;
            x_valid_d = 1'b1;
            x_out_d   = word_at(i_data, '0);
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d     = cnt_inc_c;
          x_valid_d = 1'b1;
          x_out_d   = word_at(data_q, cnt_inc_c);
          x_last_d  = (cnt_inc_c == LAST_IDX);
`ifdef LAYER_SER_OVERRUN_EN
          if (capture_c) overrun_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = x_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      x_valid_q <= 1'b0;
      x_out_q   <= '0;
      x_last_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef LAYER_SER_OVERRUN_EN
      overrun_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_valid_q <= x_valid_d;
      x_out_q   <= x_out_d;
      x_last_q  <= x_last_d;
      busy_q    <= busy_d;
`ifdef LAYER_SER_OVERRUN_EN
      overrun_q <= overrun_d;
`endif
    end
  end

  // Capture register contents are don't-care after reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign x_valid = x_valid_q;
  assign x_out   = x_out_q;
  assign x_last  = x_last_q;
  assign busy    = busy_q;
`ifdef LAYER_SER_OVERRUN_EN
  assign overrun = overrun_q;
`endif

endmodule
